// File: rtl/funnel_seq.sv
// ---------------------------------------------------------------------------
// funnel_seq
//
// Purpose:
//   Accepts one wide word (CHUNKS * CHUNK_W bits) plus a config byte from an
//   upstream valid/ready interface and replays it as CHUNKS narrow chunks,
//   chunk 0 first, on a downstream valid/ready interface. When the last
//   chunk is taken, a waiting word is loaded in the same cycle, so the
//   chunk stream has no bubble between words.
//
// Parameters:
//   CHUNK_W  narrow chunk width in bits (default 32)
//   CHUNKS   chunks per wide word, power of two in 2..128 (default 4)
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset      in   synchronous, active-high reset
//   t_dat      in   wide input word; chunk k = t_dat[(k+1)*CHUNK_W-1 : k*CHUNK_W]
//   t_cfg      in   config byte captured together with t_dat
//   t_valid    in   upstream word valid
//   t_ready    out  word accepted this cycle when t_valid is also high
//   i_dat      out  current chunk of the held word
//   i_valid    out  i_dat valid (a word is held)
//   i_ready    in   downstream accepts the current chunk
//   i_last     out  current chunk is chunk CHUNKS-1
//   sel        out  current chunk index, zero-extended to 8 bits
//   mode       out  t_cfg captured with the held word
//   stall_cnt  out  count of cycles with i_valid && !i_ready
//
// Configuration:
//   FUNNEL_SEQ_STALL_CNT_EN  when defined, stall_cnt is a saturating 16-bit
//                            counter cleared only by reset; otherwise it is
//                            tied to zero and no counter exists.
// ---------------------------------------------------------------------------
module funnel_seq #(
  parameter int CHUNK_W = 32,
  parameter int CHUNKS  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHUNKS*CHUNK_W-1:0] t_dat,
  input  logic [7:0]                t_cfg,
  input  logic                      t_valid,
  output logic                      t_ready,
  output logic [CHUNK_W-1:0]        i_dat,
  output logic                      i_valid,
  input  logic                      i_ready,
  output logic                      i_last,
  output logic [7:0]                sel,
  output logic [7:0]                mode,
  output logic [15:0]               stall_cnt
);

  localparam int CNT_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHUNKS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                         state;
  state_t                         state_next;
  logic [CNT_W-1:0]               cnt;
  logic [CNT_W-1:0]               cnt_next;
  logic [CHUNKS-1:0][CHUNK_W-1:0] hold;
  logic                           at_last;
  logic                           word_acc;
  logic                           chunk_acc;
  logic                           load;

  // Output chunk is selected purely from registered state so it stays
  // stable while the downstream stalls.
  assign i_dat = hold[cnt];
  assign sel   = 8'(cnt);

  // Handshake decode and next-state logic. t_ready in SEND depends on
  // i_ready combinationally: a new word may only enter when the last chunk
  // of the current word leaves in the same cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;

    at_last    = (cnt == LAST_IDX);
    i_valid    = (state == SEND);
    i_last     = at_last && i_valid;
    t_ready    = (state == IDLE) || (i_last && i_ready);
    word_acc   = t_valid && t_ready;
    chunk_acc  = i_valid && i_ready;

    case (state)
      IDLE: begin
        if (word_acc) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (chunk_acc) begin
          if (!at_last) begin
            cnt_next = cnt + 1'b1;
          end else if (word_acc) begin
            load     = 1'b1;
            cnt_next = '0;
          end else begin
            cnt_next   = '0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, index and word/config holding registers; reset discards any
  // partially sent word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hold  <= '0;
      mode  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load) begin
        hold <= t_dat;
        mode <= t_cfg;
      end
    end
  end

`ifdef FUNNEL_SEQ_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of cycles where a chunk is offered but not taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (i_valid && !i_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_funnel_seq.sv
// ---------------------------------------------------------------------------
// tb_funnel_seq
//
// Testbench for funnel_seq. dut1 uses the default geometry (4 x 32 bits) and
// is driven from a cycle table plus hand-written stall and mid-word reset
// sequences. dut2 uses CHUNKS=2 and is driven with random handshakes; every
// accepted word pushes its expected chunks into a queue that is popped as
// chunks are taken downstream.
// ---------------------------------------------------------------------------
module tb_funnel_seq;

  localparam logic [127:0] W0 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] W1 = 128'h88888888_77777777_66666666_55555555;

`ifdef FUNNEL_SEQ_STALL_CNT_EN
  localparam logic [15:0] STALL_EXP = 16'd3;
`else
  localparam logic [15:0] STALL_EXP = 16'd0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut1 signals
  logic         reset;
  logic [127:0] t_dat;
  logic [7:0]   t_cfg;
  logic         t_valid;
  logic         t_ready;
  logic [31:0]  i_dat;
  logic         i_valid;
  logic         i_ready;
  logic         i_last;
  logic [7:0]   sel;
  logic [7:0]   mode;
  logic [15:0]  stall_cnt;

  // dut2 signals
  logic         reset2;
  logic [63:0]  t_dat2;
  logic [7:0]   t_cfg2;
  logic         t_valid2;
  logic         t_ready2;
  logic [31:0]  i_dat2;
  logic         i_valid2;
  logic         i_ready2;
  logic         i_last2;
  logic [7:0]   sel2;
  logic [7:0]   mode2;
  logic [15:0]  stall_cnt2;

  int checkCount = 0;
  int errorCount = 0;

  funnel_seq dut1 (
    .clk       (clk),
    .reset     (reset),
    .t_dat     (t_dat),
    .t_cfg     (t_cfg),
    .t_valid   (t_valid),
    .t_ready   (t_ready),
    .i_dat     (i_dat),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_last    (i_last),
    .sel       (sel),
    .mode      (mode),
    .stall_cnt (stall_cnt)
  );

  funnel_seq #(.CHUNK_W(32), .CHUNKS(2)) dut2 (
    .clk       (clk),
    .reset     (reset2),
    .t_dat     (t_dat2),
    .t_cfg     (t_cfg2),
    .t_valid   (t_valid2),
    .t_ready   (t_ready2),
    .i_dat     (i_dat2),
    .i_valid   (i_valid2),
    .i_ready   (i_ready2),
    .i_last    (i_last2),
    .sel       (sel2),
    .mode      (mode2),
    .stall_cnt (stall_cnt2)
  );

  typedef struct packed {
    logic         rst;
    logic         tv;
    logic [127:0] td;
    logic [7:0]   tc;
    logic         ir;
    logic         chk;
    logic         e_valid;
    logic         e_last;
    logic         e_tready;
    logic [7:0]   e_sel;
    logic [7:0]   e_mode;
    logic [31:0]  e_dat;
  } vec_t;

  typedef struct packed {
    logic [7:0]  cfg;
    logic [7:0]  idx;
    logic        last;
    logic [31:0] dat;
  } sb_t;

  sb_t sbQueue[$];

  function automatic vec_t mk(logic rst, logic tv, logic [127:0] td,
                              logic [7:0] tc, logic ir, logic chk,
                              logic ev, logic el, logic etr,
                              logic [7:0] esel, logic [7:0] emode,
                              logic [31:0] edat);
    vec_t v;
    v.rst = rst;  v.tv = tv;  v.td = td;  v.tc = tc;  v.ir = ir;
    v.chk = chk;  v.e_valid = ev;  v.e_last = el;  v.e_tready = etr;
    v.e_sel = esel;  v.e_mode = emode;  v.e_dat = edat;
    return v;
  endfunction

  // Drive dut1 inputs right after a falling edge and let them settle.
  task automatic applyStimulus(input logic rst, input logic tv,
                               input logic [127:0] td, input logic [7:0] tc,
                               input logic ir);
    reset   = rst;
    t_valid = tv;
    t_dat   = td;
    t_cfg   = tc;
    i_ready = ir;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic el,
                             input logic etr, input logic [7:0] esel,
                             input logic [7:0] emode, input logic [31:0] edat);
    logic [50:0] act;
    logic [50:0] exp;
    act = {i_valid, i_last, t_ready, sel, mode, i_dat};
    exp = {ev, el, etr, esel, emode, edat};
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got valid=%b last=%b t_ready=%b sel=%h mode=%h dat=%h, want valid=%b last=%b t_ready=%b sel=%h mode=%h dat=%h",
               name, act[50], act[49], act[48], act[47:40], act[39:32], act[31:0],
               ev, el, etr, esel, emode, edat);
    end
  endtask

  task automatic checkStall(input string name, input logic [15:0] expv);
    checkCount++;
    if (stall_cnt !== expv) begin
      errorCount++;
      $display("[TB] FAIL %s: got stall_cnt=%0d want %0d", name, stall_cnt, expv);
    end
  endtask

  // Pop one expected chunk and compare it with what dut2 is offering.
  task automatic popCompare();
    sb_t e;
    sb_t a;
    checkCount++;
    if (sbQueue.size() == 0) begin
      errorCount++;
      $display("[TB] FAIL sb_underflow: got dat=%h with empty queue", i_dat2);
    end else begin
      e = sbQueue.pop_front();
      a = {mode2, sel2, i_last2, i_dat2};
      if (a !== e) begin
        errorCount++;
        $display("[TB] FAIL sb_chunk: got cfg=%h sel=%h last=%b dat=%h, want cfg=%h sel=%h last=%b dat=%h",
                 a.cfg, a.idx, a.last, a.dat, e.cfg, e.idx, e.last, e.dat);
      end
    end
  endtask

  initial begin
    vec_t vecs[21];
    logic [63:0] word2;
    logic [7:0]  cfg2;
    logic        accepted;
    int          rxCount;

    reset2   = 1'b1;
    t_valid2 = 1'b0;
    t_dat2   = '0;
    t_cfg2   = '0;
    i_ready2 = 1'b0;

    // ---------------- table: reset idle, single word, back-to-back -------
    vecs[0]  = mk(1, 0, '0, 8'h00, 1, 0, 0, 0, 1, 8'd0, 8'h00, 32'h0);
    for (int i = 1; i <= 5; i++)
      vecs[i] = mk(0, 0, '0, 8'h00, 1, 1, 0, 0, 1, 8'd0, 8'h00, 32'h0);
    vecs[6]  = mk(0, 1, W0, 8'hA5, 1, 1, 0, 0, 1, 8'd0, 8'h00, 32'h0);
    vecs[7]  = mk(0, 0, '0, 8'h00, 1, 1, 1, 0, 0, 8'd0, 8'hA5, 32'h11111111);
    vecs[8]  = mk(0, 0, '0, 8'h00, 1, 1, 1, 0, 0, 8'd1, 8'hA5, 32'h22222222);
    vecs[9]  = mk(0, 0, '0, 8'h00, 1, 1, 1, 0, 0, 8'd2, 8'hA5, 32'h33333333);
    vecs[10] = mk(0, 0, '0, 8'h00, 1, 1, 1, 1, 1, 8'd3, 8'hA5, 32'h44444444);
    vecs[11] = mk(0, 1, W0, 8'hA5, 1, 1, 0, 0, 1, 8'd0, 8'hA5, 32'h11111111);
    vecs[12] = mk(0, 1, W1, 8'h3C, 1, 1, 1, 0, 0, 8'd0, 8'hA5, 32'h11111111);
    vecs[13] = mk(0, 1, W1, 8'h3C, 1, 1, 1, 0, 0, 8'd1, 8'hA5, 32'h22222222);
    vecs[14] = mk(0, 1, W1, 8'h3C, 1, 1, 1, 0, 0, 8'd2, 8'hA5, 32'h33333333);
    vecs[15] = mk(0, 1, W1, 8'h3C, 1, 1, 1, 1, 1, 8'd3, 8'hA5, 32'h44444444);
    vecs[16] = mk(0, 0, '0, 8'h00, 1, 1, 1, 0, 0, 8'd0, 8'h3C, 32'h55555555);
    vecs[17] = mk(0, 0, '0, 8'h00, 1, 1, 1, 0, 0, 8'd1, 8'h3C, 32'h66666666);
    vecs[18] = mk(0, 0, '0, 8'h00, 1, 1, 1, 0, 0, 8'd2, 8'h3C, 32'h77777777);
    vecs[19] = mk(0, 0, '0, 8'h00, 1, 1, 1, 1, 1, 8'd3, 8'h3C, 32'h88888888);
    vecs[20] = mk(0, 0, '0, 8'h00, 1, 1, 0, 0, 1, 8'd0, 8'h3C, 32'h55555555);

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].tv, vecs[i].td, vecs[i].tc, vecs[i].ir);
      if (vecs[i].chk)
        checkOutput($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_last,
                    vecs[i].e_tready, vecs[i].e_sel, vecs[i].e_mode, vecs[i].e_dat);
      @(negedge clk);
    end
    checkStall("stall_after_table", 16'd0);

    // ---------------- downstream stall at sel=2 --------------------------
    applyStimulus(1, 1, W1, 8'h3C, 1);   // reset wins over a presented word
    @(negedge clk);
    applyStimulus(0, 1, W0, 8'hA5, 1);
    checkOutput("post_reset_idle", 0, 0, 1, 8'd0, 8'h00, 32'h0);
    checkStall("post_reset_stall", 16'd0);
    @(negedge clk);
    applyStimulus(0, 0, '0, 8'h00, 1);
    @(negedge clk);
    applyStimulus(0, 0, '0, 8'h00, 1);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, W1, 8'h3C, 0);
      checkOutput($sformatf("stall%0d", k), 1, 0, 0, 8'd2, 8'hA5, 32'h33333333);
      @(negedge clk);
    end
    applyStimulus(0, 0, '0, 8'h00, 1);
    checkOutput("stall_release", 1, 0, 0, 8'd2, 8'hA5, 32'h33333333);
    checkStall("stall_count", STALL_EXP);
    @(negedge clk);
    applyStimulus(0, 0, '0, 8'h00, 1);
    checkOutput("stall_last", 1, 1, 1, 8'd3, 8'hA5, 32'h44444444);
    @(negedge clk);

    // ---------------- reset mid-word at sel=1 ----------------------------
    applyStimulus(0, 1, W1, 8'h3C, 1);
    @(negedge clk);
    applyStimulus(0, 0, '0, 8'h00, 1);
    checkOutput("mid_c0", 1, 0, 0, 8'd0, 8'h3C, 32'h55555555);
    @(negedge clk);
    applyStimulus(1, 0, '0, 8'h00, 1);
    checkOutput("mid_c1", 1, 0, 0, 8'd1, 8'h3C, 32'h66666666);
    @(negedge clk);
    applyStimulus(0, 1, W0, 8'hA5, 1);
    checkOutput("mid_after_reset", 0, 0, 1, 8'd0, 8'h00, 32'h0);
    checkStall("mid_stall_cleared", 16'd0);
    @(negedge clk);
    applyStimulus(0, 0, '0, 8'h00, 1);
    checkOutput("mid_new_c0", 1, 0, 0, 8'd0, 8'hA5, 32'h11111111);
    @(negedge clk);

    // ---------------- CHUNKS=2 random scoreboard -------------------------
    reset2 = 1'b1;
    @(negedge clk);
    reset2  = 1'b0;
    rxCount = 0;
    word2   = {$urandom, $urandom};
    cfg2    = 8'($urandom);
    for (int c = 0; c < 10000; c++) begin
      t_valid2 = 1'($urandom_range(0, 1));
      i_ready2 = 1'($urandom_range(0, 1));
      t_dat2   = word2;
      t_cfg2   = cfg2;
      accepted = 1'b0;
      #4;
      if (i_valid2 && i_ready2) begin
        popCompare();
        rxCount++;
      end
      if (t_valid2 && t_ready2) begin
        sbQueue.push_back({cfg2, 8'd0, 1'b0, word2[31:0]});
        sbQueue.push_back({cfg2, 8'd1, 1'b1, word2[63:32]});
        accepted = 1'b1;
      end
      @(negedge clk);
      if (accepted) begin
        word2 = {$urandom, $urandom};
        cfg2  = 8'($urandom);
      end
    end
    t_valid2 = 1'b0;
    i_ready2 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #4;
      if (i_valid2 && i_ready2) begin
        popCompare();
        rxCount++;
      end
      @(negedge clk);
    end
    checkCount++;
    if (sbQueue.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL sb_drain: got %0d chunks left, want 0", sbQueue.size());
    end
    checkCount++;
    if (rxCount < 2000) begin
      errorCount++;
      $display("[TB] FAIL sb_volume: got %0d chunks, want at least 2000", rxCount);
    end
    $display("[TB] dut2 chunks received %0d, stall cycles %0d", rxCount, stall_cnt2);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
